mrs: RTL and testbench
======================

# mrs

Accumulator-operand source selector for the 16-bit datapath. Steers either the accumulator value (`inAc`) or the memory read value (`inMem`) onto a single 16-bit operand bus. The operand bus is combinational. A clocked copy of the selected operand, the select, and status flags is provided for the control unit and for pipeline/debug use. The block sits between the accumulator/data-memory read ports and the ALU/accumulator input.

## Interface
Parameters:
- `WIDTH`, default 16: data width of both inputs and all data outputs.

Ports (clock and reset first). One clock; reset is asynchronous and active-high.
- `clk`, input, 1: rising-edge clock for all registered outputs.
- `reset`, input, 1: asynchronous, active-high reset of all registered outputs.
- `inAc`, input, WIDTH: accumulator operand.
- `inMem`, input, WIDTH: memory operand.
- `choice`, input, 1: source select. 0 selects `inAc`; 1 selects `inMem`.
- `out`, output, WIDTH: selected operand, combinational.
- `out_q`, output, WIDTH: registered copy of `out`.
- `choice_q`, output, 1: registered copy of `choice`.
- `zero_q`, output, 1: registered flag; 1 when the selected operand is all zeros.
- `neg_q`, output, 1: registered flag; equals the MSB (bit WIDTH-1) of the selected operand.
- `sel_changed`, output, 1: registered pulse; 1 for one cycle when `choice` differs from the `choice_q` sampled at the previous edge.

## Operation
- Combinational path: `out = choice ? inMem : inAc`.
  - No arithmetic is applied; the selected word passes through bit-exact.
  - If `choice` is X or Z, `out` must not silently pick a source. Simulation must propagate X.
- Registered path, on each rising `clk` edge while `reset` is 0:
  - `out_q` ← `out`.
  - `choice_q` ← `choice`.
  - `zero_q` ← (`out == 0`).
  - `neg_q` ← `out[WIDTH-1]`.
  - `sel_changed` ← (`choice != choice_q`).
- There is no enable and no hold: the registers update every cycle.
- There is no state machine and no handshake. The block is always ready.

## Timing
- `out`: zero-cycle latency. It follows any change on `inAc`, `inMem`, or `choice` within the same delta/cycle, independent of `clk` and `reset`.
- Registered outputs: one-cycle latency. They reflect the inputs sampled at the previous rising edge.
- Reset values. When `reset` is asserted, these values apply immediately, with no clock edge required, and hold while `reset` = 1:
  - `out_q` = 0
  - `choice_q` = 0
  - `zero_q` = 1, consistent with `out_q` = 0
  - `neg_q` = 0
  - `sel_changed` = 0
- Reset does not affect `out`.
- First edge after reset deassertion:
  - `sel_changed` compares against the reset value of `choice_q`, which is 0.
  - If `choice` = 1 at that edge, `sel_changed` pulses.
- Reset asserted mid-stream: registered outputs clear asynchronously. No partial update is retained.
- An input change coincident with the clock edge is sampled with standard setup semantics. `out` reflects the new value immediately regardless.

## Test plan
- Combinational select, `choice` = 1:
  - Apply `inAc` = 90 (0x005A), `inMem` = 188 (0x00BC), `choice` = 1.
  - Required: `out` = 188 immediately.
  - After one `clk` edge: `out_q` = 188, `choice_q` = 1, `zero_q` = 0, `neg_q` = 0.
- Combinational select, `choice` = 0:
  - 20 ns later, apply `inAc` = 95 (0x005F), `inMem` = 188, `choice` = 0.
  - Required: `out` = 95 with no clock.
  - Next edge: `out_q` = 95 and `sel_changed` = 1 for exactly one cycle.
- Asynchronous reset:
  - Assert `reset` between clock edges.
  - Required, immediately: `out_q` = 0, `choice_q` = 0, `zero_q` = 1, `neg_q` = 0, `sel_changed` = 0.
  - `out` still tracks the inputs during reset.
- Flag boundaries, with `choice` = 1:
  - `inMem` = 0x0000 → `zero_q` = 1, `neg_q` = 0.
  - `inMem` = 0x8000 → `zero_q` = 0, `neg_q` = 1.
  - `inMem` = 0xFFFF → `neg_q` = 1, and `out` = 0xFFFF bit-exact.
- Select toggling every cycle, with `inAc` = 0x1234, `inMem` = 0xABCD:
  - `out_q` alternates 0x1234 / 0xABCD with one-cycle lag.
  - `sel_changed` stays 1 on every edge after the first toggle.
- Unused-input independence:
  - With `choice` = 0, randomize `inMem` for 100 cycles.
  - Required: `out` and `out_q` remain equal to the held `inAc`.

Source files
------------

// File: rtl/mrs.sv
// mrs: accumulator-operand source selector.
// Steers the accumulator or memory read word onto a single operand bus.
// It also keeps a one-cycle registered copy of the operand, the select,
// and zero/negative flags for the control unit and for debug visibility.
module mrs #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] inAc,
   input  logic [WIDTH-1:0] inMem,
   input  logic             choice,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_q,
   output logic             choice_q,
   output logic             zero_q,
   output logic             neg_q,
   output logic             sel_changed
);

   // Operand bus: a plain two-way steer with no arithmetic applied.
   // The conditional operator is used instead of an if/else. An unknown
   // select then merges both sources and yields X where they differ,
   // rather than quietly falling through to one branch.
   always_comb begin
      out = choice ? inMem : inAc;
   end

   // ---- stage boundary: operand bus -> registered copies ----
   // Snapshot the operand, select and flags every cycle.
   // Reset clears everything asynchronously. zero_q resets to 1 so that it
   // agrees with the cleared out_q.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_q       <= '0;
         choice_q    <= 1'b0;
         zero_q      <= 1'b1;
         neg_q       <= 1'b0;
         sel_changed <= 1'b0;
      end else begin
         out_q       <= out;
         choice_q    <= choice;
         zero_q      <= (out == '0);
         neg_q       <= out[WIDTH-1];
         sel_changed <= (choice != choice_q);
      end
   end

endmodule

// File: tb/tb_mrs.sv
// tb_mrs: directed plus randomized checks of the mrs operand selector.
// A source-indexed reference model predicts every observed output.
module tb_mrs;
   localparam int W = 16;

   logic         clk;
   logic         reset;
   logic [W-1:0] inAc;
   logic [W-1:0] inMem;
   logic         choice;
   logic [W-1:0] out;
   logic [W-1:0] out_q;
   logic         choice_q;
   logic         zero_q;
   logic         neg_q;
   logic         sel_changed;

   int n_cmp = 0;
   int n_err = 0;

   // Reference state: the select value the model last saw at a clock edge.
   logic m_choice;

   mrs #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .inAc        (inAc),
      .inMem       (inMem),
      .choice      (choice),
      .out         (out),
      .out_q       (out_q),
      .choice_q    (choice_q),
      .zero_q      (zero_q),
      .neg_q       (neg_q),
      .sel_changed (sel_changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: pick a word from a two-entry source table.
   function automatic logic [W-1:0] pick(input logic c, input logic [W-1:0] a, input logic [W-1:0] m);
      logic [W-1:0] src [2];
      src[0] = a;
      src[1] = m;
      return src[c];
   endfunction

   // Check the combinational bus, clock once, then check the registered outputs.
   task automatic step(input string tag);
      logic [W-1:0] e_out;
      logic         e_ch;
      logic         e_zero;
      logic         e_neg;
      logic         e_sc;
      #1;
      e_out  = pick(choice, inAc, inMem);
      e_ch   = choice;
      e_zero = (e_out == 0) ? 1'b1 : 1'b0;
      e_neg  = (e_out >= (1 << (W - 1))) ? 1'b1 : 1'b0;
      e_sc   = (choice == m_choice) ? 1'b0 : 1'b1;
      chk({tag, ".out"}, out, e_out);
      m_choice = choice;
      @(posedge clk);
      #1;
      chk({tag, ".out_q"}, out_q, e_out);
      chk({tag, ".choice_q"}, W'(choice_q), W'(e_ch));
      chk({tag, ".zero_q"}, W'(zero_q), W'(e_zero));
      chk({tag, ".neg_q"}, W'(neg_q), W'(e_neg));
      chk({tag, ".sel_changed"}, W'(sel_changed), W'(e_sc));
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, ".out_q"}, out_q, 16'h0000);
      chk({tag, ".choice_q"}, W'(choice_q), 16'h0000);
      chk({tag, ".zero_q"}, W'(zero_q), 16'h0001);
      chk({tag, ".neg_q"}, W'(neg_q), 16'h0000);
      chk({tag, ".sel_changed"}, W'(sel_changed), 16'h0000);
   endtask

   initial begin
      reset    = 1'b1;
      inAc     = 16'h1111;
      inMem    = 16'h2222;
      choice   = 1'b1;
      m_choice = 1'b0;

      // Reset values are present before any clock edge has occurred.
      #2;
      chk_reset_vals("rst0");
      chk("rst0.out_tracks", out, 16'h2222);

      @(negedge clk);
      reset = 1'b0;

      // Combinational select with choice = 1.
      inAc = 16'd90; inMem = 16'd188; choice = 1'b1;
      #1;
      chk("sel1.out_imm", out, 16'd188);
      step("sel1");
      chk("sel1.first_edge_pulse", W'(sel_changed), 16'h0001);

      // Combinational select with choice = 0. The change pulses for one cycle only.
      @(negedge clk);
      inAc = 16'd95; inMem = 16'd188; choice = 1'b0;
      #1;
      chk("sel0.out_imm", out, 16'd95);
      step("sel0");
      chk("sel0.pulse", W'(sel_changed), 16'h0001);
      step("sel0.hold");
      chk("sel0.pulse_gone", W'(sel_changed), 16'h0000);

      // Flag boundaries.
      choice = 1'b1;
      inMem = 16'h0000; step("flag0");
      chk("flag0.zero", W'(zero_q), 16'h0001);
      inMem = 16'h8000; step("flag8000");
      chk("flag8000.neg", W'(neg_q), 16'h0001);
      chk("flag8000.zero", W'(zero_q), 16'h0000);
      inMem = 16'hFFFF; step("flagFFFF");
      chk("flagFFFF.out_q", out_q, 16'hFFFF);
      chk("flagFFFF.neg", W'(neg_q), 16'h0001);

      // Select toggling every cycle.
      inAc = 16'h1234; inMem = 16'hABCD;
      for (int i = 0; i < 8; i++) begin
         choice = ~choice;
         step("toggle");
         chk("toggle.pulse", W'(sel_changed), 16'h0001);
         chk("toggle.out_q", out_q, choice ? 16'hABCD : 16'h1234);
      end

      // The unused memory input has no effect while choice = 0.
      choice = 1'b0;
      inAc = 16'h5A5A;
      for (int i = 0; i < 100; i++) begin
         inMem = W'($urandom);
         step("indep");
         chk("indep.out", out, 16'h5A5A);
         chk("indep.out_q", out_q, 16'h5A5A);
      end

      // Fully random traffic.
      for (int i = 0; i < 200; i++) begin
         inAc   = W'($urandom);
         inMem  = W'($urandom);
         choice = 1'($urandom_range(0, 1));
         if ((i % 17) == 0) inMem = 16'h0000;
         step("rand");
      end

      // Asynchronous reset in mid-stream, asserted between clock edges.
      inAc = 16'hC3C3; inMem = 16'h8001; choice = 1'b1;
      step("pre_rst");
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("rst_mid");
      chk("rst_mid.out_tracks", out, 16'h8001);
      choice = 1'b0;
      #1;
      chk("rst_mid.out_tracks2", out, 16'hC3C3);
      @(posedge clk);
      #1;
      chk_reset_vals("rst_hold");
      @(negedge clk);
      reset = 1'b0;
      m_choice = 1'b0;
      choice = 1'b1;
      step("post_rst");
      chk("post_rst.pulse", W'(sel_changed), 16'h0001);
      for (int i = 0; i < 20; i++) begin
         inAc   = W'($urandom);
         inMem  = W'($urandom);
         choice = 1'($urandom_range(0, 1));
         step("rand2");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
